// File: rtl/wb_select_stage.sv
// Write-back select stage: picks write data/address/enable from MEM results and
// registers them behind a two-entry skid buffer. WB_SELECT_LINK8_EN selects pc+8 as link value.
module wb_select_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NSRC  = 3,
  localparam int unsigned SELW = $clog2(NSRC + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NSRC*WIDTH-1:0]   in_src,
  input  logic [SELW-1:0]         in_sel,
  input  logic [1:0]              in_regdst,
  input  logic [4:0]              in_rt,
  input  logic [4:0]              in_rd,
  input  logic                    in_regwrite,
  input  logic [WIDTH-1:0]        in_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_we,
  output logic [4:0]              out_wa,
  output logic [WIDTH-1:0]        out_wd
);

`ifdef WB_SELECT_LINK8_EN
  localparam int unsigned LINK_OFS = 8;
`else
  localparam int unsigned LINK_OFS = 4;
`endif

  typedef struct packed {
    logic             we;
    logic [4:0]       wa;
    logic [WIDTH-1:0] wd;
  } beat_t;

  beat_t            new_beat;
  logic [WIDTH-1:0] sel_wd;
  logic [4:0]       sel_wa;

  beat_t m_q, m_d, s_q, s_d;
  logic  m_valid_q, m_valid_d;
  logic  s_valid_q, s_valid_d;
  logic  ready_q;
  logic  accept, drain;

  // Source mux: data sources, then link, anything above reads as zero.
  always_comb begin
    sel_wd = '0;
    for (int k = 0; k < int'(NSRC); k++) begin
      if (in_sel == SELW'(k)) sel_wd = in_src[k*WIDTH +: WIDTH];
    end
    if (in_sel == SELW'(NSRC)) sel_wd = in_pc + WIDTH'(LINK_OFS);
  end

  // Destination mux and $0 write suppression.
  always_comb begin
    sel_wa = 5'd31;
    case (in_regdst)
      2'b00:   sel_wa = in_rt;
      2'b01:   sel_wa = in_rd;
      default: sel_wa = 5'd31;
    endcase
    new_beat    = '0;
    new_beat.wa = sel_wa;
    new_beat.wd = sel_wd;
    new_beat.we = in_regwrite & (sel_wa != 5'd0);
  end

  assign accept = in_valid & ready_q;
  assign drain  = m_valid_q & out_ready;

  // Next state for main/skid entries; flush dominates everything.
  always_comb begin
    m_d       = m_q;
    s_d       = s_q;
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      m_d.we    = 1'b0;
    end else if (drain || !m_valid_q) begin
      if (s_valid_q) begin
        m_d       = s_q;
        m_valid_d = 1'b1;
        s_valid_d = 1'b0;
      end else if (accept) begin
        m_d       = new_beat;
        m_valid_d = 1'b1;
      end else begin
        m_valid_d = 1'b0;
        m_d.we    = 1'b0;
      end
    end else if (accept) begin
      s_d       = new_beat;
      s_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q       <= '0;
      s_q       <= '0;
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      m_q       <= m_d;
      s_q       <= s_d;
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      ready_q   <= ~s_valid_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = m_valid_q;
  assign out_we    = m_q.we;
  assign out_wa    = m_q.wa;
  assign out_wd    = m_q.wd;

endmodule

// File: tb/tb_wb_select_stage.sv
// Bench for wb_select_stage: queue-based occupancy model checked every cycle plus directed literals.
module tb_wb_select_stage;

`ifdef WB_SELECT_LINK8_EN
  localparam logic [31:0] LO = 32'd8;
`else
  localparam logic [31:0] LO = 32'd4;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] src [3];
  logic [95:0] in_src;
  logic [1:0]  in_sel = '0;
  logic [1:0]  in_regdst = '0;
  logic [4:0]  in_rt = '0;
  logic [4:0]  in_rd = '0;
  logic        in_regwrite = 1'b0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_we;
  logic [4:0]  out_wa;
  logic [31:0] out_wd;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit        we;
    bit [4:0]  wa;
    bit [31:0] wd;
  } mbeat_t;

  mbeat_t      q[$];
  logic [31:0] rec[$];

  assign in_src = {src[2], src[1], src[0]};

  wb_select_stage dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_src(in_src), .in_sel(in_sel),
    .in_regdst(in_regdst), .in_rt(in_rt), .in_rd(in_rd), .in_regwrite(in_regwrite),
    .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_we(out_we), .out_wa(out_wa), .out_wd(out_wd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic mbeat_t model_beat();
    mbeat_t b;
    case (in_sel)
      2'd0: b.wd = src[0];
      2'd1: b.wd = src[1];
      2'd2: b.wd = src[2];
      default: b.wd = in_pc + LO;
    endcase
    b.wa = (in_regdst == 2'd0) ? in_rt : (in_regdst == 2'd1) ? in_rd : 5'd31;
    b.we = in_regwrite && (b.wa != 0);
    return b;
  endfunction

  // Occupancy model: queue head is what the output must show; at most two entries held.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) q.delete();
    else if (flush) q.delete();
    else begin
      bit acc, drn;
      mbeat_t nb;
      acc = in_valid && (q.size() < 2);
      drn = (q.size() > 0) && out_ready;
      nb  = model_beat();
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(nb);
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("m_out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("m_in_ready", 32'(in_ready), 32'(q.size() < 2));
      if (q.size() > 0) begin
        chk("m_out_we", 32'(out_we), 32'(q[0].we));
        chk("m_out_wa", 32'(out_wa), 32'(q[0].wa));
        chk("m_out_wd", out_wd, q[0].wd);
        if (out_ready) rec.push_back(out_wd);
      end else begin
        chk("m_out_we_idle", 32'(out_we), 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] sel, input logic [1:0] rdst, input logic [4:0] rt,
                      input logic [4:0] rd, input logic rw, input logic [31:0] pc);
    bit ok, done;
    done        = 0;
    in_sel      = sel;
    in_regdst   = rdst;
    in_rt       = rt;
    in_rd       = rd;
    in_regwrite = rw;
    in_pc       = pc;
    in_valid    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ok = in_ready;
      step();
      if (ok) begin
        done = 1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!done) chk("push_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    src[0] = 32'h11;
    src[1] = 32'h22;
    src[2] = 32'h33;
    #22 reset_n = 1'b1;
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_we", 32'(out_we), 32'd0);
    chk("rst_out_wa", 32'(out_wa), 32'd0);
    chk("rst_out_wd", out_wd, 32'd0);
    repeat (10) step();
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_out_wa", 32'(out_wa), 32'd0);
    chk("idle_out_wd", out_wd, 32'd0);

    // Source selection with a free-running sink
    push(2'd0, 2'd0, 5'd5, 5'd9, 1'b1, 32'h3000);
    chk("sel0_wd", out_wd, 32'h11);
    push(2'd1, 2'd0, 5'd5, 5'd9, 1'b1, 32'h3000);
    chk("sel1_wd", out_wd, 32'h22);
    push(2'd2, 2'd0, 5'd5, 5'd9, 1'b1, 32'h3000);
    chk("sel2_wd", out_wd, 32'h33);
    push(2'd3, 2'd0, 5'd5, 5'd9, 1'b1, 32'h3000);
    chk("link_wd", out_wd, 32'h3000 + LO);

    // Destination selection
    push(2'd0, 2'd0, 5'd5, 5'd9, 1'b1, 32'h0);
    chk("rt_wa", 32'(out_wa), 32'd5);
    chk("rt_we", 32'(out_we), 32'd1);
    push(2'd0, 2'd1, 5'd5, 5'd9, 1'b1, 32'h0);
    chk("rd_wa", 32'(out_wa), 32'd9);
    push(2'd0, 2'd2, 5'd5, 5'd9, 1'b1, 32'h0);
    chk("r31_wa", 32'(out_wa), 32'd31);
    push(2'd0, 2'd0, 5'd0, 5'd9, 1'b1, 32'h0);
    chk("r0_wa", 32'(out_wa), 32'd0);
    chk("r0_we", 32'(out_we), 32'd0);
    step();
    chk("drained_valid", 32'(out_valid), 32'd0);

    // Back-pressure: A..D back to back, sink stalled three cycles from A appearing
    rec.delete();
    out_ready = 1'b0;
    push(2'd0, 2'd0, 5'd1, 5'd0, 1'b1, 32'h0);
    chk("bp_a_visible", out_wd, 32'h11);
    push(2'd1, 2'd0, 5'd2, 5'd0, 1'b1, 32'h0);
    chk("bp_ready_low", 32'(in_ready), 32'd0);
    chk("bp_a_stable", out_wd, 32'h11);
    fork
      push(2'd2, 2'd0, 5'd3, 5'd0, 1'b1, 32'h0);
      begin
        step();
        out_ready = 1'b1;
      end
    join
    push(2'd3, 2'd0, 5'd4, 5'd0, 1'b1, 32'h3000);
    repeat (3) step();
    chk("bp_count", 32'(rec.size()), 32'd4);
    if (rec.size() == 4) begin
      chk("bp_order0", rec[0], 32'h11);
      chk("bp_order1", rec[1], 32'h22);
      chk("bp_order2", rec[2], 32'h33);
      chk("bp_order3", rec[3], 32'h3000 + LO);
    end

    // Flush with both entries full and a simultaneous incoming beat
    out_ready = 1'b0;
    push(2'd0, 2'd0, 5'd6, 5'd0, 1'b1, 32'h0);
    push(2'd1, 2'd0, 5'd7, 5'd0, 1'b1, 32'h0);
    chk("fl_full", 32'(in_ready), 32'd0);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_sel   = 2'd2;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    chk("fl_out_we", 32'(out_we), 32'd0);
    out_ready = 1'b1;
    repeat (3) step();
    chk("fl_beat_lost", 32'(out_valid), 32'd0);

    // PC wrap on the link value
    push(2'd3, 2'd2, 5'd0, 5'd0, 1'b1, 32'hFFFF_FFFC);
    chk("wrap_wd", out_wd, 32'hFFFF_FFFC + LO);
    chk("wrap_wa", 32'(out_wa), 32'd31);
    step();

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    push(2'd0, 2'd0, 5'd5, 5'd0, 1'b1, 32'h0);
    push(2'd1, 2'd0, 5'd6, 5'd0, 1'b1, 32'h0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_we", 32'(out_we), 32'd0);
    chk("arst_out_wa", 32'(out_wa), 32'd0);
    chk("arst_out_wd", out_wd, 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    #10 reset_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
